// File: rtl/resizer.sv
// resizer: lane-compacting stream width converter, S_KEEP_WIDTH-lane slave to M_KEEP_WIDTH-lane master.
// latency: a beat can be presented the cycle after the edge that wrote its completing lane; no s_* to m_* path.
// backpressure: s_ready_o from registered occupancy only; master outputs come from registered state and hold while stalled.
module resizer #(
   parameter int S_KEEP_WIDTH     = 2,
   parameter int T_DATA_WIDTH     = 4,
   parameter int M_KEEP_WIDTH     = 3,
   parameter int MULTIPLIER       = 2,
   parameter int BUF_IN_ENTRY_SZ  = (2+T_DATA_WIDTH)*S_KEEP_WIDTH,
   parameter int BUF_OUT_ENTRY_SZ = (2+T_DATA_WIDTH)*M_KEEP_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid_i,
   input  logic                        s_last_i,
   input  logic [S_KEEP_WIDTH-1:0]     s_keep_i,
   input  logic [T_DATA_WIDTH-1:0]     s_data_i [S_KEEP_WIDTH],
   output logic                        s_ready_o,
   output logic                        m_valid_o,
   input  logic                        m_ready_i,
   output logic                        m_last_o,
   output logic [M_KEEP_WIDTH-1:0]     m_keep_o,
   output logic [T_DATA_WIDTH-1:0]     m_data_o [M_KEEP_WIDTH],
   output logic                        overflow,
   output logic                        underflow,
   output logic                        slave_entry_valid,
   output logic [BUF_IN_ENTRY_SZ-1:0]  slave_entry,
   output logic                        master_entry_ready,
   output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry
);

   localparam int DEPTH = MULTIPLIER*(S_KEEP_WIDTH+M_KEEP_WIDTH);
   localparam int RW    = T_DATA_WIDTH+2;        // lane record {keep, last, data}
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH+1);

   logic [RW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [RW-1:0] comp_rec [S_KEEP_WIDTH];
   logic [RW-1:0] head_rec [M_KEEP_WIDTH];
   int            push_n;
   int            beat_len;
   logic          found;
   logic          push, pop;
   int            push_n_eff, pop_n_eff;

   // Circular pointer advance; offsets never exceed DEPTH so one subtraction suffices.
   function automatic logic [PW-1:0] wrap(input int base, input int off);
      int s;
      s = base + off;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   assign s_ready_o          = (DEPTH - int'(count_q)) >= S_KEEP_WIDTH;
   assign overflow           = s_valid_i & ~s_ready_o;
   assign underflow          = m_ready_i & ~m_valid_o;
   assign slave_entry_valid  = s_valid_i & s_ready_o;
   assign master_entry_ready = m_valid_o & m_ready_i;

   // Compact kept input lanes to the bottom; last rides on the highest kept lane only.
   always_comb begin
      int   rank;
      logic top;
      rank   = 0;
      top    = 1'b0;
      push_n = 0;
      for (int i = 0; i < S_KEEP_WIDTH; i++)
         if (s_keep_i[i]) push_n = push_n + 1;
      for (int p = 0; p < S_KEEP_WIDTH; p++) begin
         comp_rec[p] = '0;
         rank = 0;
         for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            if (s_keep_i[i]) begin
               if (rank == p) begin
                  top = 1'b1;
                  for (int j = i+1; j < S_KEEP_WIDTH; j++)
                     if (s_keep_i[j]) top = 1'b0;
                  comp_rec[p] = {1'b1, s_last_i & top, s_data_i[i]};
               end
               rank = rank + 1;
            end
         end
      end
      slave_entry = '0;
      for (int p = 0; p < S_KEEP_WIDTH; p++)
         slave_entry[p*RW +: RW] = comp_rec[p];
   end

   // Form the output beat from the oldest records: stop at the first last, else need a full beat.
   always_comb begin
      int            cnt;
      logic [RW-1:0] out_rec;
      cnt      = int'(count_q);
      found    = 1'b0;
      beat_len = 0;
      out_rec  = '0;
      for (int r = 0; r < M_KEEP_WIDTH; r++) begin
         head_rec[r] = mem_q[wrap(int'(rd_ptr_q), r)];
         if (!found && r < cnt && head_rec[r][T_DATA_WIDTH]) begin
            found    = 1'b1;
            beat_len = r + 1;
         end
      end
      if (!found && cnt >= M_KEEP_WIDTH) beat_len = M_KEEP_WIDTH;
      m_valid_o    = beat_len != 0;
      m_last_o     = found;
      m_keep_o     = '0;
      master_entry = '0;
      for (int r = 0; r < M_KEEP_WIDTH; r++) begin
         out_rec     = (r < beat_len) ? head_rec[r] : '0;
         m_keep_o[r] = out_rec[RW-1];
         m_data_o[r] = out_rec[T_DATA_WIDTH-1:0];
         master_entry[r*RW +: RW] = out_rec;
      end
   end

   // Occupancy and pointer next-state from this cycle's push and pop.
   always_comb begin
      push       = s_valid_i & s_ready_o;
      pop        = m_valid_o & m_ready_i;
      push_n_eff = push ? push_n : 0;
      pop_n_eff  = pop ? beat_len : 0;
      count_d    = CW'(int'(count_q) + push_n_eff - pop_n_eff);
      wr_ptr_d   = wrap(int'(wr_ptr_q), push_n_eff);
      rd_ptr_d   = wrap(int'(rd_ptr_q), pop_n_eff);
   end

   // FIFO state; reset discards any buffered lanes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int p = 0; p < S_KEEP_WIDTH; p++)
            if (push && p < push_n) mem_q[wrap(int'(wr_ptr_q), p)] <= comp_rec[p];
      end
   end

endmodule

// File: tb/tb_resizer.sv
// tb_resizer: table vectors, hand sequences and random traffic against a packet-segmentation model.
// Model: kept lanes are cut into M-lane pieces per packet, the final piece carrying last.
// All DUT outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_resizer;
   localparam int S = 2, T = 4, M = 3, DEPTH = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_valid_i, s_last_i, s_ready_o;
   logic [S-1:0] s_keep_i;
   logic [T-1:0] s_data_i [S];
   logic         m_valid_o, m_ready_i, m_last_o;
   logic [M-1:0] m_keep_o;
   logic [T-1:0] m_data_o [M];
   logic         overflow, underflow, slave_entry_valid, master_entry_ready;
   logic [11:0]  slave_entry;
   logic [17:0]  master_entry;

   always #5 clk = ~clk;

   resizer dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_keep_i(s_keep_i), .s_data_i(s_data_i),
      .s_ready_o(s_ready_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
      .m_keep_o(m_keep_o), .m_data_o(m_data_o),
      .overflow(overflow), .underflow(underflow),
      .slave_entry_valid(slave_entry_valid), .slave_entry(slave_entry),
      .master_entry_ready(master_entry_ready), .master_entry(master_entry)
   );

   typedef struct packed {
      logic [1:0]   len;
      logic         lst;
      logic [M*T-1:0] d;
   } beat_t;

   beat_t        bq[$];     // complete expected beats, oldest first
   logic [T-1:0] part[$];   // lanes of the open packet not yet forming a beat
   int           occ = 0;   // lanes the DUT should be holding
   int           checks = 0, errors = 0;
   logic         rnd_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic push_lane(input logic [T-1:0] d, input logic l);
      beat_t nb;
      part.push_back(d);
      occ++;
      if (l || part.size() == M) begin
         nb     = '0;
         nb.len = 2'(part.size());
         nb.lst = l;
         for (int r = 0; r < part.size(); r++) nb.d[r*T +: T] = part[r];
         bq.push_back(nb);
         part.delete();
      end
   endtask

   // Per-cycle scoreboard: compare against the model, then apply this cycle's pop and push.
   always @(negedge clk) begin : mon
      beat_t        b;
      logic         ev, er;
      logic [17:0]  me;
      logic [11:0]  se;
      logic [M-1:0] ek;
      logic [T-1:0] kq[$];
      if (!rst_n) begin
         bq.delete();
         part.delete();
         occ = 0;
      end else begin
         ev = (bq.size() != 0);
         er = ((DEPTH - occ) >= S);
         b  = ev ? bq[0] : '0;
         chk("s_ready", 32'(s_ready_o), 32'(er));
         chk("m_valid", 32'(m_valid_o), 32'(ev));
         chk("overflow", 32'(overflow), 32'(s_valid_i & ~er));
         chk("underflow", 32'(underflow), 32'(m_ready_i & ~ev));
         chk("slave_entry_valid", 32'(slave_entry_valid), 32'(s_valid_i & er));
         chk("master_entry_ready", 32'(master_entry_ready), 32'(ev & m_ready_i));
         me = '0;
         ek = '0;
         for (int r = 0; r < M; r++) begin
            if (r < int'(b.len)) begin
               me[r*6 +: 6] = {1'b1, b.lst && (r == int'(b.len) - 1), b.d[r*T +: T]};
               ek[r] = 1'b1;
            end
            chk("m_data", 32'(m_data_o[r]), 32'(me[r*6 +: 4]));
         end
         chk("master_entry", 32'(master_entry), 32'(me));
         chk("m_keep", 32'(m_keep_o), 32'(ek));
         chk("m_last", 32'(m_last_o), 32'(ev & b.lst));
         if (ev && m_ready_i) begin
            occ = occ - int'(b.len);
            void'(bq.pop_front());
         end
         if (s_valid_i && er) begin
            kq.delete();
            for (int i = 0; i < S; i++) if (s_keep_i[i]) kq.push_back(s_data_i[i]);
            se = '0;
            for (int p = 0; p < kq.size(); p++)
               se[p*6 +: 6] = {1'b1, s_last_i && (p == kq.size() - 1), kq[p]};
            chk("slave_entry", 32'(slave_entry), 32'(se));
            for (int p = 0; p < kq.size(); p++) push_lane(kq[p], s_last_i && (p == kq.size() - 1));
         end
      end
   end

   // Present a beat and hold it until accepted (bounded); returns 1 unit after the accepting edge.
   task automatic send(input logic [S-1:0] k, input logic l, input logic [T-1:0] d0, input logic [T-1:0] d1);
      int   w;
      logic done;
      s_valid_i = 1'b1; s_keep_i = k; s_last_i = l; s_data_i[0] = d0; s_data_i[1] = d1;
      w = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (s_ready_o || w >= 200) done = 1'b1;
         else begin
            @(posedge clk); #1;
            w++;
            if (rnd_rdy) m_ready_i = ($urandom_range(0, 3) != 0);
         end
      end
      chk("send_accept", 32'(s_ready_o), 32'd1);
      @(posedge clk); #1;
      s_valid_i = 1'b0;
      if (rnd_rdy) m_ready_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      @(negedge clk);
      while ((bq.size() != 0 || part.size() != 0) && w < 300) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk); #1;
      chk("drain_occ", 32'(occ), 32'd0);
      chk("drain_valid", 32'(m_valid_o), 32'd0);
   endtask

   typedef struct {
      logic [S-1:0] k;
      logic         l;
      logic [T-1:0] d0, d1;
      logic [11:0]  se;
   } vec_t;
   vec_t tbl[9];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [T-1:0] h0, h1, h2;
      logic [M-1:0] hk;

      tbl[0] = '{2'b11, 1'b0, 4'd1,  4'd0,  12'h821};
      tbl[1] = '{2'b11, 1'b0, 4'd1,  4'd0,  12'h821};
      tbl[2] = '{2'b11, 1'b1, 4'd6,  4'd7,  12'hDE6};
      tbl[3] = '{2'b11, 1'b1, 4'd13, 4'd14, 12'hFAD};
      tbl[4] = '{2'b11, 1'b1, 4'd4,  4'd5,  12'hD64};
      tbl[5] = '{2'b10, 1'b1, 4'd15, 4'd9,  12'h039};
      tbl[6] = '{2'b01, 1'b0, 4'd3,  4'd8,  12'h023};
      tbl[7] = '{2'b00, 1'b0, 4'd5,  4'd5,  12'h000};
      tbl[8] = '{2'b01, 1'b1, 4'd2,  4'd11, 12'h032};

      // Reset state, with inputs active to exercise the combinational taps.
      rst_n = 1'b0; m_ready_i = 1'b1;
      s_valid_i = 1'b1; s_last_i = 1'b0; s_keep_i = 2'b11; s_data_i[0] = 4'd1; s_data_i[1] = 4'd0;
      #2;
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("rst_m_last", 32'(m_last_o), 32'd0);
      chk("rst_m_keep", 32'(m_keep_o), 32'd0);
      chk("rst_m_data", 32'({m_data_o[2], m_data_o[1], m_data_o[0]}), 32'd0);
      chk("rst_s_ready", 32'(s_ready_o), 32'd1);
      chk("rst_master_entry", 32'(master_entry), 32'd0);
      chk("rst_master_entry_ready", 32'(master_entry_ready), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd1);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_slave_entry_valid", 32'(slave_entry_valid), 32'd1);
      chk("rst_slave_entry", 32'(slave_entry), 32'h821);
      @(posedge clk); @(posedge clk); #1;
      s_valid_i = 1'b0;
      rst_n = 1'b1;

      // Table: compaction of each beat; the scoreboard checks the resulting master beats.
      for (int i = 0; i < 9; i++) begin
         s_valid_i = 1'b1; s_keep_i = tbl[i].k; s_last_i = tbl[i].l;
         s_data_i[0] = tbl[i].d0; s_data_i[1] = tbl[i].d1;
         #1;
         chk("tbl_slave_entry", 32'(slave_entry), 32'(tbl[i].se));
         send(tbl[i].k, tbl[i].l, tbl[i].d0, tbl[i].d1);
      end
      wait_drain();

      // Waiting for a full beat, then a split tail.
      send(2'b11, 1'b0, 4'd1, 4'd0);
      repeat (3) @(negedge clk);
      chk("wait_m_valid", 32'(m_valid_o), 32'd0);
      chk("wait_underflow", 32'(underflow), 32'd1);
      @(posedge clk); #1;
      send(2'b11, 1'b1, 4'd2, 4'd3);
      @(negedge clk);
      chk("split1_keep", 32'(m_keep_o), 32'b111);
      chk("split1_last", 32'(m_last_o), 32'd0);
      chk("split1_data", 32'({m_data_o[2], m_data_o[1], m_data_o[0]}), 32'h201);
      @(negedge clk);
      chk("split2_keep", 32'(m_keep_o), 32'b001);
      chk("split2_last", 32'(m_last_o), 32'd1);
      chk("split2_data", 32'({m_data_o[2], m_data_o[1], m_data_o[0]}), 32'h003);
      @(posedge clk); #1;
      wait_drain();

      // Backpressure: fill to DEPTH, hold a sixth beat, check stability, then drain.
      m_ready_i = 1'b0;
      for (int b = 0; b < 5; b++) send(2'b11, b == 4, 4'(2*b), 4'(2*b+1));
      @(negedge clk);
      chk("full_s_ready", 32'(s_ready_o), 32'd0);
      @(posedge clk); #1;
      s_valid_i = 1'b1; s_keep_i = 2'b11; s_last_i = 1'b1; s_data_i[0] = 4'd10; s_data_i[1] = 4'd11;
      @(negedge clk);
      chk("full_overflow", 32'(overflow), 32'd1);
      h0 = m_data_o[0]; h1 = m_data_o[1]; h2 = m_data_o[2]; hk = m_keep_o;
      chk("stall_head", 32'({h2, h1, h0}), 32'h210);
      @(negedge clk);
      chk("stall_stable_data", 32'({m_data_o[2], m_data_o[1], m_data_o[0]}), 32'({h2, h1, h0}));
      chk("stall_stable_keep", 32'(m_keep_o), 32'(hk));
      @(posedge clk); #1;
      m_ready_i = 1'b1;
      send(2'b11, 1'b1, 4'd10, 4'd11);
      wait_drain();

      // Simultaneous push and pop at 8 lanes, then a pop at 9 lanes.
      m_ready_i = 1'b0;
      for (int b = 0; b < 4; b++) send(2'b11, 1'b0, 4'(2*b), 4'(2*b+1));
      m_ready_i = 1'b1;
      send(2'b11, 1'b0, 4'd8, 4'd9);
      m_ready_i = 1'b0;
      send(2'b11, 1'b0, 4'd10, 4'd11);
      s_valid_i = 1'b1; s_keep_i = 2'b11; s_last_i = 1'b1; s_data_i[0] = 4'd12; s_data_i[1] = 4'd13;
      @(negedge clk);
      chk("nine_s_ready", 32'(s_ready_o), 32'd0);
      chk("nine_overflow", 32'(overflow), 32'd1);
      @(posedge clk); #1;
      m_ready_i = 1'b1;
      @(negedge clk);
      chk("pop_no_same_cycle_ready", 32'(s_ready_o), 32'd0);
      @(posedge clk); #1;
      m_ready_i = 1'b0;
      @(negedge clk);
      chk("after_pop_s_ready", 32'(s_ready_o), 32'd1);
      @(posedge clk); #1;
      send(2'b11, 1'b1, 4'd12, 4'd13);
      m_ready_i = 1'b1;
      wait_drain();

      // Reset with a partial packet buffered.
      m_ready_i = 1'b0;
      send(2'b11, 1'b0, 4'd7, 4'd7);
      send(2'b11, 1'b0, 4'd7, 4'd7);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", 32'(m_valid_o), 32'd0);
      chk("midrst_s_ready", 32'(s_ready_o), 32'd1);
      chk("midrst_master_entry", 32'(master_entry), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      m_ready_i = 1'b1;
      send(2'b11, 1'b1, 4'd5, 4'd6);
      @(negedge clk);
      chk("postrst_keep", 32'(m_keep_o), 32'b011);
      chk("postrst_last", 32'(m_last_o), 32'd1);
      chk("postrst_data", 32'({m_data_o[2], m_data_o[1], m_data_o[0]}), 32'h065);
      @(posedge clk); #1;
      wait_drain();

      // Random traffic with random master stalls.
      rnd_rdy = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         logic [S-1:0] k;
         k = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
            m_ready_i = ($urandom_range(0, 3) != 0);
         end else begin
            send(k, (k != 2'b00) && ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         end
      end
      rnd_rdy = 1'b0;
      m_ready_i = 1'b1;
      send(2'b01, 1'b1, 4'd9, 4'd0);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
